// File: rtl/lsu_ctrl.sv
// Load/store unit: formats core requests for the data-memory req/gnt bus and
// tracks one outstanding transaction, reporting misalignment and timeouts.
module lsu_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_type_i,
    input  logic                  lsu_sign_ext_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [31:0]           lsu_wdata_i,
    output logic                  lsu_busy_o,
    output logic                  lsu_rvalid_o,
    output logic [31:0]           lsu_rdata_o,
    output logic                  lsu_err_misaligned_o,
    output logic                  lsu_err_timeout_o,
    output logic                  data_req,
    input  logic                  data_gnt,
    output logic                  data_we,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [3:0]            data_be,
    output logic [31:0]           data_wdata,
    input  logic                  data_rvalid,
    input  logic [31:0]           data_rdata,
    output logic [1:0]            dbg_state_o
);
    // Bus handshake: data_req rises with all bus fields valid and they stay
    // frozen until the cycle data_gnt is sampled high; one response follows.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_off;
    logic [1:0]      r_type;
    logic            r_sign;

    logic [1:0]      w_off;
    logic            w_misaligned;
    logic            w_tmo;
    logic [31:0]     w_shifted;
    logic [31:0]     w_load_data;

    assign w_off        = lsu_addr_i[1:0];
    assign w_misaligned = (lsu_type_i == 2'b11)
                        | ((lsu_type_i == 2'b01) & w_off[0])
                        | ((lsu_type_i == 2'b10) & (w_off != 2'b00));
    assign w_tmo        = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
    assign w_shifted    = data_rdata >> {r_off, 3'b000};
    assign lsu_busy_o   = (r_state != S_IDLE);
    assign dbg_state_o  = r_state;

    always_comb begin
        w_load_data = w_shifted;
        case (r_type)
            2'b00:   w_load_data = {{24{r_sign & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state              <= S_IDLE;
            r_cnt                <= '0;
            r_off                <= 2'b00;
            r_type               <= 2'b00;
            r_sign               <= 1'b0;
            lsu_rvalid_o         <= 1'b0;
            lsu_rdata_o          <= 32'h0;
            lsu_err_misaligned_o <= 1'b0;
            lsu_err_timeout_o    <= 1'b0;
            data_req             <= 1'b0;
            data_we              <= 1'b0;
            data_addr            <= '0;
            data_be              <= 4'b0000;
            data_wdata           <= 32'h0;
        end else begin
            lsu_rvalid_o         <= 1'b0;
            lsu_err_misaligned_o <= 1'b0;
            lsu_err_timeout_o    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (lsu_req_i) begin
                        if (w_misaligned) begin
                            lsu_err_misaligned_o <= 1'b1;
                        end else begin
                            r_state    <= S_REQ;
                            r_off      <= w_off;
                            r_type     <= lsu_type_i;
                            r_sign     <= lsu_sign_ext_i;
                            data_req   <= 1'b1;
                            data_we    <= lsu_we_i;
                            data_addr  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            data_wdata <= lsu_wdata_i << {w_off, 3'b000};
                            case (lsu_type_i)
                                2'b00:   data_be <= 4'b0001 << w_off;
                                2'b01:   data_be <= 4'b0011 << w_off;
                                default: data_be <= 4'b1111;
                            endcase
                        end
                    end
                end
                S_REQ: begin
                    // Grant beats the timeout when both land in the same cycle.
                    if (data_gnt) begin
                        r_state  <= S_WAIT;
                        data_req <= 1'b0;
                        r_cnt    <= r_cnt + CNT_ONE;
                    end else if (w_tmo) begin
                        r_state           <= S_IDLE;
                        data_req          <= 1'b0;
                        lsu_err_timeout_o <= 1'b1;
                        r_cnt             <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_WAIT: begin
                    if (data_rvalid) begin
                        r_state      <= S_IDLE;
                        lsu_rvalid_o <= 1'b1;
                        lsu_rdata_o  <= data_we ? 32'h0 : w_load_data;
                        r_cnt        <= '0;
                    end else if (w_tmo) begin
                        r_state           <= S_IDLE;
                        lsu_err_timeout_o <= 1'b1;
                        r_cnt             <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    data_req <= 1'b0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: formatting, handshake timing, errors and reset.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [1:0]  lsu_type_i = 2'b00;
    logic        lsu_sign_ext_i = 1'b0;
    logic [31:0] lsu_addr_i = 32'h0;
    logic [31:0] lsu_wdata_i = 32'h0;
    logic        lsu_busy_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_misaligned_o;
    logic        lsu_err_timeout_o;
    logic        data_req;
    logic        data_gnt = 1'b0;
    logic        data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid = 1'b0;
    logic [31:0] data_rdata = 32'h0;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
        .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_busy_o(lsu_busy_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_err_misaligned_o(lsu_err_misaligned_o), .lsu_err_timeout_o(lsu_err_timeout_o),
        .data_req(data_req), .data_gnt(data_gnt), .data_we(data_we), .data_addr(data_addr),
        .data_be(data_be), .data_wdata(data_wdata), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    {31'h0, data_req},             32'h0);
        chk({tag, "_we"},     {31'h0, data_we},              32'h0);
        chk({tag, "_addr"},   data_addr,                     32'h0);
        chk({tag, "_be"},     {28'h0, data_be},              32'h0);
        chk({tag, "_wdata"},  data_wdata,                    32'h0);
        chk({tag, "_rvalid"}, {31'h0, lsu_rvalid_o},         32'h0);
        chk({tag, "_rdata"},  lsu_rdata_o,                   32'h0);
        chk({tag, "_mis"},    {31'h0, lsu_err_misaligned_o}, 32'h0);
        chk({tag, "_tmo"},    {31'h0, lsu_err_timeout_o},    32'h0);
        chk({tag, "_busy"},   {31'h0, lsu_busy_o},           32'h0);
        chk({tag, "_state"},  {30'h0, dbg_state_o},          32'h0);
    endtask

    task automatic issue(input logic we, input logic [1:0] typ, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdat);
        lsu_req_i      = 1'b1;
        lsu_we_i       = we;
        lsu_type_i     = typ;
        lsu_sign_ext_i = sgn;
        lsu_addr_i     = addr;
        lsu_wdata_i    = wdat;
    endtask

    // Minimum-latency transaction: request in cycle 0, gnt in 1, rvalid in 2.
    task automatic txn(input string tag, input logic we, input logic [1:0] typ,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdat,
                       input logic [31:0] bus_rdata, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_rdata);
        issue(we, typ, sgn, addr, wdat);
        tick();
        lsu_req_i = 1'b0;
        chk({tag, "_req1"},  {31'h0, data_req},   32'h1);
        chk({tag, "_addr"},  data_addr,           exp_addr);
        chk({tag, "_be"},    {28'h0, data_be},    {28'h0, exp_be});
        chk({tag, "_wdata"}, data_wdata,          exp_wdata);
        chk({tag, "_we"},    {31'h0, data_we},    {31'h0, we});
        chk({tag, "_busy1"}, {31'h0, lsu_busy_o}, 32'h1);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        chk({tag, "_req2"},  {31'h0, data_req},   32'h0);
        chk({tag, "_busy2"}, {31'h0, lsu_busy_o}, 32'h1);
        data_rvalid = 1'b1;
        data_rdata  = bus_rdata;
        tick();
        data_rvalid = 1'b0;
        data_rdata  = 32'h0;
        chk({tag, "_rvalid3"}, {31'h0, lsu_rvalid_o}, 32'h1);
        chk({tag, "_rdata"},   lsu_rdata_o,           exp_rdata);
        chk({tag, "_busy3"},   {31'h0, lsu_busy_o},   32'h0);
        tick();
        chk({tag, "_rvalid4"}, {31'h0, lsu_rvalid_o}, 32'h0);
        chk({tag, "_hold"},    lsu_rdata_o,           exp_rdata);
    endtask

    initial begin
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        txn("st_word", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,
            32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
        txn("ld_sbyte", 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80123456,
            32'h200, 4'b1000, 32'h0, 32'hFFFFFF80);
        txn("ld_ubyte", 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80123456,
            32'h200, 4'b1000, 32'h0, 32'h00000080);
        txn("ld_uhalf", 1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 32'hBEEF1234,
            32'h300, 4'b1100, 32'h0, 32'h0000BEEF);
        txn("st_byte", 1'b1, 2'b00, 1'b0, 32'h301, 32'h000000A5, 32'h0,
            32'h300, 4'b0010, 32'h0000A500, 32'h0);
        txn("ld_shalf", 1'b0, 2'b01, 1'b1, 32'h500, 32'h0, 32'h1234C001,
            32'h500, 4'b0011, 32'h0, 32'hFFFFC001);

        // Misaligned word and illegal type: one error pulse each, no bus activity.
        issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        tick();
        lsu_req_i = 1'b0;
        chk("mis_word_pulse", {31'h0, lsu_err_misaligned_o}, 32'h1);
        chk("mis_word_req",   {31'h0, data_req},             32'h0);
        chk("mis_word_busy",  {31'h0, lsu_busy_o},           32'h0);
        tick();
        chk("mis_word_once",  {31'h0, lsu_err_misaligned_o}, 32'h0);
        chk("mis_word_req2",  {31'h0, data_req},             32'h0);
        issue(1'b1, 2'b11, 1'b0, 32'h100, 32'h12345678);
        tick();
        lsu_req_i = 1'b0;
        chk("mis_ill_pulse", {31'h0, lsu_err_misaligned_o}, 32'h1);
        chk("mis_ill_req",   {31'h0, data_req},             32'h0);
        chk("mis_ill_busy",  {31'h0, lsu_busy_o},           32'h0);
        tick();
        chk("mis_ill_once",  {31'h0, lsu_err_misaligned_o}, 32'h0);

        // Grant delayed by 4 cycles; a second request is held throughout.
        issue(1'b1, 2'b01, 1'b0, 32'h402, 32'h0000ABCD);
        tick();
        issue(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("dly_req",   {31'h0, data_req}, 32'h1);
            chk("dly_addr",  data_addr,         32'h400);
            chk("dly_be",    {28'h0, data_be},  32'h0000000C);
            chk("dly_wdata", data_wdata,        32'hABCD0000);
            chk("dly_we",    {31'h0, data_we},  32'h1);
            tick();
        end
        chk("dly_req5",  {31'h0, data_req}, 32'h1);
        chk("dly_addr5", data_addr,         32'h400);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        chk("dly_wait_req",  {31'h0, data_req},   32'h0);
        chk("dly_wait_busy", {31'h0, lsu_busy_o}, 32'h1);
        data_rvalid = 1'b1;
        data_rdata  = 32'h11223344;
        tick();
        data_rvalid = 1'b0;
        chk("dly_rvalid", {31'h0, lsu_rvalid_o}, 32'h1);
        chk("dly_rdata",  lsu_rdata_o,           32'h0);
        chk("dly_busy",   {31'h0, lsu_busy_o},   32'h0);
        tick();
        lsu_req_i = 1'b0;
        chk("b2b_req",  {31'h0, data_req}, 32'h1);
        chk("b2b_addr", data_addr,         32'h500);
        chk("b2b_we",   {31'h0, data_we},  32'h0);
        chk("b2b_be",   {28'h0, data_be},  32'h0000000F);
        data_gnt = 1'b1;
        tick();
        data_gnt    = 1'b0;
        data_rvalid = 1'b1;
        data_rdata  = 32'hCAFEF00D;
        tick();
        data_rvalid = 1'b0;
        chk("b2b_rvalid", {31'h0, lsu_rvalid_o}, 32'h1);
        chk("b2b_rdata",  lsu_rdata_o,           32'hCAFEF00D);
        tick();

        // Timeout: grant given, no response; abort after 8 cycles in REQ+WAIT.
        issue(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
        tick();
        lsu_req_i = 1'b0;
        data_gnt  = 1'b1;
        tick();
        data_gnt = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            chk("tmo_busy",    {31'h0, lsu_busy_o},        32'h1);
            chk("tmo_nopulse", {31'h0, lsu_err_timeout_o}, 32'h0);
            tick();
        end
        chk("tmo_pulse",  {31'h0, lsu_err_timeout_o}, 32'h1);
        chk("tmo_rvalid", {31'h0, lsu_rvalid_o},      32'h0);
        chk("tmo_busy9",  {31'h0, lsu_busy_o},        32'h0);
        chk("tmo_req",    {31'h0, data_req},          32'h0);
        chk("tmo_rdata",  lsu_rdata_o,                32'hCAFEF00D);
        tick();
        chk("tmo_once",   {31'h0, lsu_err_timeout_o}, 32'h0);

        // Asynchronous reset while waiting for the response.
        issue(1'b0, 2'b10, 1'b0, 32'h700, 32'h0);
        tick();
        lsu_req_i = 1'b0;
        data_gnt  = 1'b1;
        tick();
        data_gnt = 1'b0;
        chk("rst_in_wait", {30'h0, dbg_state_o}, 32'h2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        rst_n       = 1'b1;
        data_rvalid = 1'b1;
        data_rdata  = 32'h55555555;
        tick();
        data_rvalid = 1'b0;
        chk("rst_no_rvalid", {31'h0, lsu_rvalid_o}, 32'h0);
        chk("rst_no_tmo",    {31'h0, lsu_err_timeout_o}, 32'h0);
        chk("rst_idle",      {30'h0, dbg_state_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Parametrised load/store unit between the execute stage and the data-memory request/grant bus.
- Accepts one load or store per request: byte, halfword or word; signed or unsigned loads.
- Produces word-aligned bus address, byte enables and lane-shifted write data; extracts and extends load data.
- Tracks a single outstanding transaction through an IDLE/REQ/WAIT FSM, with misalignment and response-timeout error reporting.

Parameters:
- ADDR_WIDTH, 32, width of lsu_addr_i and data_addr.
- TIMEOUT_CYCLES, 64, max cycles spent in REQ+WAIT before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lsu_req_i  in  1  core request valid; sampled only in IDLE.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_type_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- lsu_sign_ext_i  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- lsu_addr_i  in  ADDR_WIDTH  byte address (ALU result).
- lsu_wdata_i  in  32  store data, right-aligned.
- lsu_busy_o  out  1  FSM not in IDLE.
- lsu_rvalid_o  out  1  one-cycle completion pulse for loads and stores.
- lsu_rdata_o  out  32  formatted load data; 0 on store completion.
- lsu_err_misaligned_o  out  1  one-cycle pulse: misaligned or illegal request.
- lsu_err_timeout_o  out  1  one-cycle pulse: transaction aborted.
- data_req  out  1  bus request.
- data_gnt  in  1  bus grant.
- data_we  out  1  bus write enable.
- data_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- data_be  out  4  byte enables.
- data_wdata  out  32  lane-aligned write data.
- data_rvalid  in  1  read/write response valid.
- data_rdata  in  32  bus read data.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE; the timeout counter clears.
  - All outputs go to 0, including lsu_rdata_o.
  - Reset mid-transaction drops data_req immediately; no completion or error pulse is generated.
- All outputs are registered except lsu_busy_o, which is decoded from state.
- Offset: off = lsu_addr_i[1:0].
- Misaligned/illegal: type 11; half with off[0]=1; word with off!=0.
- IDLE with lsu_req_i=1:
  - If misaligned: stay in IDLE, pulse lsu_err_misaligned_o next cycle, no bus activity.
  - Otherwise: register the request, go to REQ. data_req=1 next cycle.
  - data_addr = {addr[ADDR_WIDTH-1:2],2'b00}.
  - data_be = 0001<<off (byte), 0011<<off (half), 1111 (word).
  - data_wdata = lsu_wdata_i << (8*off).
  - data_we = lsu_we_i.
- REQ:
  - data_req, data_addr, data_be, data_we and data_wdata are held stable until data_gnt=1.
  - On data_gnt: data_req=0 next cycle, go to WAIT.
  - data_rvalid while in REQ is ignored.
- WAIT: on data_rvalid, go to IDLE; next cycle lsu_rvalid_o=1 and lsu_rdata_o is set:
  - Load: s = data_rdata >> (8*off), then s[7:0] or s[15:0] sign- or zero-extended to 32; word passes through.
  - Store: lsu_rdata_o = 0.
- Completion timing:
  - lsu_busy_o is 0 in the lsu_rvalid_o cycle, and a new lsu_req_i is accepted in that same cycle.
  - lsu_rdata_o holds its value until the next completion.
- Minimum latency: request at cycle 0, data_req at 1, gnt at 1, rvalid at 2, lsu_rvalid_o at 3.
- Timeout:
  - Counter increments each cycle in REQ or WAIT and clears on entry to IDLE.
  - When the count equals TIMEOUT_CYCLES-1 with no gnt (REQ) or no rvalid (WAIT): go to IDLE, data_req=0, pulse lsu_err_timeout_o, no lsu_rvalid_o.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Simultaneous events:
  - If data_rvalid and the timeout condition occur in the same cycle, completion wins.
  - data_gnt takes priority over the timeout in REQ.
- lsu_req_i while busy is ignored; the core must hold it.

Test Plan:
- Store word 0xDEADBEEF @0x100, gnt same cycle as req, rvalid next cycle -> data_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; lsu_rvalid_o at cycle 3, rdata=0.
- Signed byte load @0x203, data_rdata=0x80123456 -> be=1000, lsu_rdata_o=0xFFFFFF80; same load unsigned -> 0x00000080.
- Unsigned half load @0x302, data_rdata=0xBEEF1234 -> be=1100, lsu_rdata_o=0x0000BEEF; byte store 0xA5 @0x301 -> be=0010, wdata=0x0000A500.
- Word load @0x101, and type=11 @0x100 -> lsu_err_misaligned_o pulses once each, data_req stays 0, lsu_busy_o stays 0.
- data_gnt delayed 4 cycles -> data_req and all bus fields stable throughout; new lsu_req_i while busy is ignored; back-to-back request accepted in the lsu_rvalid_o cycle.
- TIMEOUT_CYCLES=8, gnt given, no rvalid -> lsu_err_timeout_o pulse after 8 cycles in REQ+WAIT, no lsu_rvalid_o.
- rst_n low during WAIT -> data_req=0 and all outputs 0 immediately, FSM in IDLE.
